// File: rtl/fan_ctrl_sequencer.sv
// rtl/fan_ctrl_sequencer.sv - control-step scheduler: prescaler, ADC handshake, PI compute strobe.
// Optional ADC watchdog compiled in with FANSEQ_WATCHDOG_EN.
module fan_ctrl_sequencer #(
  parameter int CLK_FREQ     = 1_000_000,
  parameter int STEP_FREQ    = 5,
  parameter int ADC_BITWIDTH = 4,
  parameter int ADC_TIMEOUT  = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  output logic                    adc_start_o,
  input  logic                    adc_done_i,
  input  logic [ADC_BITWIDTH-1:0] adc_data_i,
  input  logic [ADC_BITWIDTH-1:0] set_i,
  output logic [ADC_BITWIDTH-1:0] adc_value_o,
  output logic [ADC_BITWIDTH-1:0] set_value_o,
  output logic                    calc_start_o,
  input  logic                    calc_done_i,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    fault_o
);

  localparam int DIV = CLK_FREQ / STEP_FREQ - 1;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_C = CW'(DIV);

  typedef enum logic [1:0] {IDLE, SAMPLE, CALC_START, CALC_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          load;
  logic          wd_expire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             cnt <= '0;
    else if (!en_i)        cnt <= '0;
    else if (cnt == DIV_C) cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign tick = en_i && (cnt == DIV_C);

`ifdef FANSEQ_WATCHDOG_EN
  localparam int WW = $clog2(ADC_TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;

  // Held at zero outside SAMPLE, so every SAMPLE entry starts from a clean count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 wd_cnt <= '0;
    else if (state != SAMPLE)  wd_cnt <= '0;
    else                       wd_cnt <= wd_cnt + 1'b1;
  end

  // adc_done_i takes priority over expiry in the final cycle.
  assign wd_expire = (state == SAMPLE) && (wd_cnt == WW'(ADC_TIMEOUT - 1)) && !adc_done_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          fault_o <= 1'b0;
    else if (wd_expire) fault_o <= 1'b1;
  end
`else
  assign wd_expire = 1'b0;
  assign fault_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:       if (tick) state_nxt = SAMPLE;
      SAMPLE: begin
        if (adc_done_i) begin
          load      = 1'b1;
          state_nxt = CALC_START;
        end else if (wd_expire) begin
          state_nxt = IDLE;
        end
      end
      CALC_START: state_nxt = CALC_WAIT;
      CALC_WAIT:  if (calc_done_i) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adc_value_o <= '0;
      set_value_o <= '0;
    end else if (load) begin
      adc_value_o <= adc_data_i;
      set_value_o <= set_i;
    end
  end

  // A tick landing mid-sequence is dropped, only flagged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                         overrun_o <= 1'b0;
    else if (tick && (state != IDLE))  overrun_o <= 1'b1;
  end

  assign adc_start_o  = (state == SAMPLE);
  assign calc_start_o = (state == CALC_START);
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_fan_ctrl_sequencer.sv
// tb/tb_fan_ctrl_sequencer.sv - directed self-checking bench for fan_ctrl_sequencer.
module tb_fan_ctrl_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i  = 1'b1;
  logic       adc_start_o;
  logic       adc_done_i = 1'b0;
  logic [3:0] adc_data_i = 4'h0;
  logic [3:0] set_i      = 4'h0;
  logic [3:0] adc_value_o;
  logic [3:0] set_value_o;
  logic       calc_start_o;
  logic       calc_done_i = 1'b0;
  logic       busy_o;
  logic       overrun_o;
  logic       fault_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cnt;
  logic seen;

  fan_ctrl_sequencer #(
    .CLK_FREQ(20), .STEP_FREQ(1), .ADC_BITWIDTH(4), .ADC_TIMEOUT(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .adc_start_o(adc_start_o), .adc_done_i(adc_done_i), .adc_data_i(adc_data_i),
    .set_i(set_i), .adc_value_o(adc_value_o), .set_value_o(set_value_o),
    .calc_start_o(calc_start_o), .calc_done_i(calc_done_i), .busy_o(busy_o),
    .overrun_o(overrun_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_adc_start"},  {31'd0, adc_start_o},  32'd0);
    chk({tag, "_calc_start"}, {31'd0, calc_start_o}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy_o},       32'd0);
    chk({tag, "_overrun"},    {31'd0, overrun_o},    32'd0);
    chk({tag, "_fault"},      {31'd0, fault_o},      32'd0);
    chk({tag, "_adc_value"},  {28'd0, adc_value_o},  32'd0);
    chk({tag, "_set_value"},  {28'd0, set_value_o},  32'd0);
  endtask

  initial begin
    // power-on reset
    step(); step();
    chk_all_zero("por");
    rst_i = 1'b0;
    cyc = 0;

    // first tick in cycle 19, request in 20
    run_to(19);
    chk("first_req_c19", {31'd0, adc_start_o}, 32'd0);
    run_to(20);
    chk("first_req_c20", {31'd0, adc_start_o}, 32'd1);

    // nominal step: done at 23, strobe at 24, calc_done at 26, idle at 27
    adc_data_i = 4'hA; set_i = 4'h6;
    busy_cnt = 1;
    run_to(23); busy_cnt += 3;
    adc_done_i = 1'b1;
    step(); adc_done_i = 1'b0; busy_cnt += int'(busy_o);
    chk("nom_strobe",    {31'd0, calc_start_o}, 32'd1);
    chk("nom_adc_value", {28'd0, adc_value_o},  32'hA);
    chk("nom_set_value", {28'd0, set_value_o},  32'h6);
    chk("nom_req_low",   {31'd0, adc_start_o},  32'd0);
    step(); busy_cnt += int'(busy_o);
    chk("nom_strobe_1cyc", {31'd0, calc_start_o}, 32'd0);
    step(); busy_cnt += int'(busy_o);
    calc_done_i = 1'b1;
    step(); calc_done_i = 1'b0; busy_cnt += int'(busy_o);
    chk("nom_busy_cycles", busy_cnt, 32'd7);

    // overrun: SAMPLE at 40, strobe at 42, calc_done withheld through tick at 59
    run_to(40);
    chk("ovr_req", {31'd0, adc_start_o}, 32'd1);
    adc_data_i = 4'h3; set_i = 4'h9;
    run_to(41); adc_done_i = 1'b1;
    step(); adc_done_i = 1'b0;
    chk("ovr_strobe",    {31'd0, calc_start_o}, 32'd1);
    chk("ovr_adc_value", {28'd0, adc_value_o},  32'h3);
    seen = 1'b0;
    while (cyc < 72) begin
      step();
      seen |= adc_start_o;
      if (cyc == 59) chk("ovr_before_tick", {31'd0, overrun_o}, 32'd0);
      if (cyc == 60) chk("ovr_after_tick",  {31'd0, overrun_o}, 32'd1);
    end
    chk("ovr_no_second_req", {31'd0, seen},   32'd0);
    chk("ovr_still_busy",    {31'd0, busy_o}, 32'd1);
    calc_done_i = 1'b1;
    step(); calc_done_i = 1'b0;
    chk("ovr_idle",   {31'd0, busy_o},    32'd0);
    chk("ovr_sticky", {31'd0, overrun_o}, 32'd1);

    // enable drop during CALC_WAIT: SAMPLE at 80, strobe 82, en low at 83
    run_to(80);
    chk("en_req", {31'd0, adc_start_o}, 32'd1);
    adc_data_i = 4'h5; set_i = 4'hC;
    run_to(81); adc_done_i = 1'b1;
    step(); adc_done_i = 1'b0;
    chk("en_set_value", {28'd0, set_value_o}, 32'hC);
    step();
    en_i = 1'b0;
    run_to(85); calc_done_i = 1'b1;
    step(); calc_done_i = 1'b0;
    chk("en_seq_done", {31'd0, busy_o}, 32'd0);
    seen = 1'b0;
    while (cyc < 110) begin
      step();
      seen |= busy_o;
    end
    chk("en_no_ticks", {31'd0, seen}, 32'd0);
    en_i = 1'b1;
    run_to(129);
    chk("en_re_c19", {31'd0, adc_start_o}, 32'd0);
    run_to(130);
    chk("en_re_c20", {31'd0, adc_start_o}, 32'd1);

`ifdef FANSEQ_WATCHDOG_EN
    // done in exactly the 8th SAMPLE cycle (130..137) beats the timeout
    adc_data_i = 4'h7; set_i = 4'h2;
    run_to(137); adc_done_i = 1'b1;
    step(); adc_done_i = 1'b0;
    chk("wd_ontime_strobe", {31'd0, calc_start_o}, 32'd1);
    chk("wd_ontime_fault",  {31'd0, fault_o},      32'd0);
    chk("wd_ontime_value",  {28'd0, adc_value_o},  32'h7);
    step(); calc_done_i = 1'b1;
    step(); calc_done_i = 1'b0;
    // no done at all: SAMPLE 150..157, IDLE with fault at 158
    adc_data_i = 4'hE; set_i = 4'h1;
    run_to(157);
    chk("wd_to_last_cycle", {31'd0, adc_start_o}, 32'd1);
    chk("wd_to_no_fault",   {31'd0, fault_o},     32'd0);
    step();
    chk("wd_to_fault",      {31'd0, fault_o},      32'd1);
    chk("wd_to_idle",       {31'd0, busy_o},       32'd0);
    chk("wd_to_no_strobe",  {31'd0, calc_start_o}, 32'd0);
    chk("wd_to_adc_hold",   {28'd0, adc_value_o},  32'h7);
    chk("wd_to_set_hold",   {28'd0, set_value_o},  32'h2);
    step();
    chk("wd_to_no_strobe2", {31'd0, calc_start_o}, 32'd0);
    run_to(172);
`else
    // no watchdog: SAMPLE holds for 100 cycles
    seen = 1'b0;
    while (cyc < 230) begin
      step();
      seen |= fault_o | ~adc_start_o;
    end
    chk("nowd_req_held", {31'd0, adc_start_o}, 32'd1);
    chk("nowd_no_drop",  {31'd0, seen},        32'd0);
    run_to(231);
`endif

    // asynchronous reset mid-SAMPLE
    chk("rst_in_sample", {31'd0, adc_start_o}, 32'd1);
    #3 rst_i = 1'b1;
    #1 chk("rst_async_drop", {31'd0, adc_start_o}, 32'd0);
    step();
    chk_all_zero("rst_mid");
    rst_i = 1'b0;
    cyc = 0;
    run_to(19);
    chk("rst_rel_c19", {31'd0, adc_start_o}, 32'd0);
    run_to(20);
    chk("rst_rel_c20", {31'd0, adc_start_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fan_ctrl_sequencer.md
# fan_ctrl_sequencer

Control-step scheduler that sits in front of the fan PI datapath. It divides the system clock down to the control-step rate, runs one acquisition handshake with the external ADC per step, and latches the ADC sample and setpoint. It then fires a single compute strobe into the PI/PWM datapath and waits for that datapath to acknowledge before the next step can begin. It replaces the free-running `clk_en_i = 1'b1` tie-off with a sequenced, fault-aware step.

## Interface
Parameters:
- `CLK_FREQ`, 1_000_000, system clock frequency in Hz.
- `STEP_FREQ`, 5, control-step rate in Hz. `DIV = CLK_FREQ/STEP_FREQ - 1`; `DIV` must be at least 8.
- `ADC_BITWIDTH`, 4, width of the ADC sample and of the setpoint.
- `ADC_TIMEOUT`, 64, watchdog limit in clock cycles. Used only when the watchdog is compiled in.

Ports:
- `clk_i`, in, 1, system clock. Single clock domain.
- `rst_i`, in, 1, asynchronous, active-high reset.
- `en_i`, in, 1, enables step generation.
- `adc_start_o`, out, 1, ADC conversion request. Level signal, held until done.
- `adc_done_i`, in, 1, ADC conversion complete. `adc_data_i` is valid in the same cycle.
- `adc_data_i`, in, ADC_BITWIDTH, ADC sample.
- `set_i`, in, ADC_BITWIDTH, setpoint. Asynchronous to the step; sampled together with the ADC data.
- `adc_value_o`, out, ADC_BITWIDTH, latched sample fed to the PI datapath.
- `set_value_o`, out, ADC_BITWIDTH, latched setpoint fed to the PI datapath.
- `calc_start_o`, out, 1, one-cycle compute strobe to the PI datapath.
- `calc_done_i`, in, 1, PI datapath has finished the update.
- `busy_o`, out, 1, high in every state except IDLE.
- `overrun_o`, out, 1, sticky. Set when a tick arrives while `busy_o` is high.
- `fault_o`, out, 1, sticky. Set on ADC timeout.

## Operation
- Prescaler `cnt`, sized by `$clog2(DIV+1)`:
  - Clears to 0 when `en_i=0`.
  - Otherwise increments each cycle.
  - When `cnt==DIV`, it wraps to 0 and asserts the internal `tick` for one cycle.
- FSM, all outputs decoded from the registered state:
  - IDLE: on `tick`, go to SAMPLE.
  - SAMPLE: `adc_start_o=1`. When `adc_done_i=1`:
    - at that edge, load `adc_value_o<=adc_data_i` and `set_value_o<=set_i`;
    - go to CALC_START.
  - CALC_START: `calc_start_o=1` for exactly one cycle, then go to CALC_WAIT. `calc_done_i` is ignored in this state.
  - CALC_WAIT: when `calc_done_i=1`, go to IDLE.
- A `tick` while not in IDLE is not queued:
  - `overrun_o<=1`;
  - the current sequence continues unchanged.
- `en_i` falling mid-sequence only stops the prescaler. The sequence in progress runs to IDLE.
- `adc_value_o` and `set_value_o` change only on a successful SAMPLE exit. Otherwise they hold.
- `fault_o` and `overrun_o` clear only on reset.
- Reset at any time, including mid-handshake:
  - state=IDLE, `cnt=0`;
  - all outputs 0, including `adc_value_o` and `set_value_o`;
  - `adc_start_o` deasserts asynchronously.

## Timing
- With `en_i` held high from reset release, the first `tick` occurs in cycle `DIV`, counting the first enabled cycle as 0. Ticks then recur every `DIV+1` cycles.
- Tick in cycle T:
  - `adc_start_o` goes high in T+1.
- `adc_done_i` sampled high in cycle D:
  - `adc_start_o` goes low and the latched outputs are valid in D+1;
  - `calc_start_o` is high in D+1 only.
- `calc_done_i` is sampled high in cycle C, with C ≥ D+2. Then `busy_o` goes low in C+1.
- Minimum step: tick to IDLE in 4 cycles, with `adc_done_i` and `calc_done_i` each returned one cycle after the request.

## Configuration
- `FANSEQ_WATCHDOG_EN` defined: ADC watchdog compiled in.
  - A cycle counter clears on SAMPLE entry and counts cycles in SAMPLE.
  - If `adc_done_i` has not been seen after `ADC_TIMEOUT` cycles in SAMPLE:
    - `fault_o<=1`;
    - go to IDLE, skipping CALC;
    - latched outputs hold their previous values.
  - If `adc_done_i` arrives in the same cycle as the timeout, `adc_done_i` wins and no fault is raised.
- `FANSEQ_WATCHDOG_EN` undefined:
  - no counter is built;
  - SAMPLE waits indefinitely;
  - `fault_o` is tied to 0.

## Test plan
All scenarios use `CLK_FREQ=20`, `STEP_FREQ=1` (`DIV=19`), `ADC_TIMEOUT=8`.
- Reset: assert `rst_i` mid-SAMPLE -> `adc_start_o` drops immediately and all outputs are 0. After release with `en_i=1`, the first `adc_start_o` rises in cycle 20.
- Nominal step:
  - stimulus: `adc_data_i=4'hA`, `set_i=4'h6`, `adc_done_i` returned 3 cycles after the request, `calc_done_i` returned 2 cycles after the strobe;
  - required: `adc_value_o=A` and `set_value_o=6` in the strobe cycle; one-cycle `calc_start_o`; `busy_o` lasts 7 cycles.
- Overrun: hold `calc_done_i=0` for 30 cycles -> `overrun_o=1` after the next tick and no second `adc_start_o` pulse. When `calc_done_i` returns, the FSM goes to IDLE and `overrun_o` stays 1.
- Enable: drop `en_i` during CALC_WAIT -> the sequence completes and no further ticks occur. Re-raise `en_i` -> the next tick arrives 19 cycles after the first enabled cycle.
- Watchdog (macro defined): no `adc_done_i` -> after 8 cycles `fault_o=1`, state IDLE, no `calc_start_o`, latched outputs unchanged. `adc_done_i` in exactly the 8th cycle -> no fault.
- Watchdog (macro undefined): no `adc_done_i` for 100 cycles -> `adc_start_o` stays high and `fault_o=0`.
